// File: rtl/fifo_fwft_pkg.sv
// Shared constants for the FWFT FIFO and the UART TX blocks that reuse its defaults.
package fifo_fwft_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 16;
    localparam int DEF_AF_THRESH = 12;
    localparam int DEF_AE_THRESH = 2;

    // Where the word waiting behind the output register currently lives.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_BYP  = 2'd1,
        SRC_RAM  = 2'd2
    } stage_src_e;

endpackage

// File: rtl/fifo_fwft_ram.sv
// Simple dual-port storage array: synchronous write, registered synchronous read, no reset.
module fifo_ram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: registered head word, a one-word prefetch stage fed from
// either the RAM read port or a write bypass, and level-derived status flags.
module fifo_fwft
    import fifo_fwft_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int AF_THRESH = DEF_AF_THRESH,
    parameter int AE_THRESH = DEF_AE_THRESH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      level_q;
    stage_src_e       a_src;
    logic [WIDTH-1:0] byp_q;
    logic [WIDTH-1:0] ram_q;
    logic [WIDTH-1:0] a_data;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;

    logic wr_ok, pop, ram_has, a_valid, b_free, a_to_b, a_free;
    logic ram_rd, ram_wr, byp_ld;

    // Words flow: RAM -> prefetch stage (a) -> output register (b). A write only bypasses
    // the RAM when nothing older sits there, so ordering is preserved by construction.
    always_comb begin
        wr_ok   = wr_en & ~full & ~flush;
        pop     = rd_en & rd_valid_q & ~flush;
        ram_has = (wr_ptr != rd_ptr);
        a_valid = (a_src != SRC_NONE);
        b_free  = ~rd_valid_q | pop;
        a_to_b  = b_free & a_valid;
        a_free  = ~a_valid | a_to_b;
        ram_rd  = a_free & ram_has & ~flush;
        byp_ld  = a_free & ~ram_has & wr_ok;
        ram_wr  = wr_ok & ~byp_ld;
        a_data  = (a_src == SRC_BYP) ? byp_q : ram_q;
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (ram_rd),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            a_src      <= SRC_NONE;
            byp_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            a_src      <= SRC_NONE;
            rd_valid_q <= 1'b0;
        end else begin
            if (ram_wr) wr_ptr <= wr_ptr + 1'b1;
            if (ram_rd) rd_ptr <= rd_ptr + 1'b1;
            level_q <= level_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, pop};
            if (b_free) rd_valid_q <= a_valid;
            if (a_to_b) rd_data_q <= a_data;
            if (byp_ld) byp_q <= wr_data;
            if (ram_rd) begin
                a_src <= SRC_RAM;
            end else if (byp_ld) begin
                a_src <= SRC_BYP;
            end else if (a_to_b) begin
                a_src <= SRC_NONE;
            end
        end
    end

    // A fresh error event in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q & ~clr_err) | (wr_en & full & ~flush);
            underflow_q <= (underflow_q & ~clr_err) | (rd_en & ~rd_valid_q & ~flush);
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign level        = level_q;
    assign full         = (level_q == (AW+1)'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= (AW+1)'(AF_THRESH));
    assign almost_empty = (level_q <= (AW+1)'(AE_THRESH));
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_fwft.sv
// Self-checking bench for fifo_fwft: directed scenarios plus randomized traffic against a queue model.
module tb_fifo_fwft;

    localparam int W     = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         rd_valid;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [4:0]   level;
    logic         overflow;
    logic         underflow;
    logic         clr_err;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of words with the edge index each was accepted on.
    logic [W-1:0] exp_q[$];
    int           exp_t[$];
    int           n_edge;
    logic [W-1:0] shown;
    logic         m_ovf;
    logic         m_unf;

    fifo_fwft dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A word accepted at edge k may be presented as head only after edge k+1.
    function automatic logic m_valid();
        return (exp_q.size() > 0) && (exp_t[0] < n_edge);
    endfunction

    function automatic void model_edge(input logic f, input logic we, input logic [W-1:0] d,
                                       input logic re, input logic ce);
        logic was_full;
        logic was_valid;
        was_full  = (exp_q.size() == DEPTH);
        was_valid = m_valid();
        n_edge++;
        m_ovf = (m_ovf & ~ce) | (we & was_full & ~f);
        m_unf = (m_unf & ~ce) | (re & ~was_valid & ~f);
        if (f) begin
            exp_q.delete();
            exp_t.delete();
        end else begin
            if (re && was_valid) begin
                void'(exp_q.pop_front());
                void'(exp_t.pop_front());
            end
            if (we && !was_full) begin
                exp_q.push_back(d);
                exp_t.push_back(n_edge);
            end
        end
    endfunction

    task automatic compare_all();
        int sz;
        sz = exp_q.size();
        if (m_valid()) shown = exp_q[0];
        check("rd_valid", rd_valid, m_valid());
        check("rd_data", rd_data, shown);
        check("level", level, sz);
        check("full", full, sz == DEPTH);
        check("empty", empty, sz == 0);
        check("almost_full", almost_full, sz >= AF);
        check("almost_empty", almost_empty, sz <= AE);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_unf);
    endtask

    task automatic step(input logic f, input logic we, input logic [W-1:0] d,
                        input logic re, input logic ce);
        flush   = f;
        wr_en   = we;
        wr_data = d;
        rd_en   = re;
        clr_err = ce;
        @(posedge clk);
        model_edge(f, we, d, re, ce);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_ae", almost_empty, 1);
        check("rst_af", almost_full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        exp_q.delete();
        exp_t.delete();
        shown = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        wr_data = '0;
        n_edge  = 0;
        shown   = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        @(negedge clk);
        do_reset();

        // First write lands exactly two edges later at the output.
        step(0, 1, 8'h11, 0, 0);
        check("lat_edge1_valid", rd_valid, 0);
        check("lat_edge1_level", level, 1);
        step(0, 0, 8'h00, 0, 0);
        check("lat_edge2_valid", rd_valid, 1);
        check("lat_edge2_data", rd_data, 8'h11);
        step(0, 0, 8'h00, 1, 0);
        check("lat_drained", empty, 1);

        // Fill to full, overflow, then drain in order.
        for (int i = 0; i < 16; i++) begin
            step(0, 1, W'(i), 0, 0);
            check("fill_level", level, i + 1);
            check("fill_af", almost_full, (i + 1) >= 12);
        end
        check("fill_full", full, 1);
        step(0, 1, 8'hFF, 0, 0);
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 16);
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", rd_valid, 1);
            check("drain_data", rd_data, i);
            step(0, 0, 8'h00, 1, 0);
        end
        check("drain_empty", empty, 1);
        step(0, 0, 8'h00, 0, 1);
        check("ovf_cleared", overflow, 0);

        // Full with simultaneous write and pop: pop only.
        for (int i = 0; i < 16; i++) step(0, 1, W'(8'h40 + i), 0, 0);
        step(0, 1, 8'hAA, 1, 0);
        check("fullrw_level", level, 15);
        check("fullrw_ovf", overflow, 1);
        check("fullrw_head", rd_data, 8'h41);
        step(1, 0, 8'h00, 0, 1);

        // Streaming write+read, two words in flight.
        step(0, 1, 8'd0, 0, 0);
        step(0, 1, 8'd1, 0, 0);
        for (int i = 2; i < 40; i++) begin
            check("stream_valid", rd_valid, 1);
            check("stream_data", rd_data, i - 2);
            step(0, 1, W'(i), 1, 0);
            check("stream_level", level, 2);
        end
        check("stream_tail0", rd_data, 38);
        step(0, 0, 8'h00, 1, 0);
        check("stream_tail1", rd_data, 39);
        step(0, 0, 8'h00, 1, 0);
        check("stream_empty", empty, 1);

        // Flush overrides concurrent traffic and leaves sticky flags alone.
        step(0, 0, 8'h00, 1, 0);
        check("unf_set", underflow, 1);
        for (int i = 0; i < 5; i++) step(0, 1, W'(8'h60 + i), 0, 0);
        step(0, 0, 8'h00, 0, 0);
        check("pre_flush_level", level, 5);
        step(1, 1, 8'h77, 1, 0);
        check("flush_level", level, 0);
        check("flush_valid", rd_valid, 0);
        check("flush_empty", empty, 1);
        check("flush_unf_kept", underflow, 1);
        step(0, 0, 8'h00, 0, 0);
        check("post_flush_level", level, 0);

        // clr_err behaviour, including a coincident new event.
        step(0, 0, 8'h00, 0, 1);
        check("unf_clr", underflow, 0);
        step(0, 0, 8'h00, 1, 0);
        check("unf_again", underflow, 1);
        step(0, 0, 8'h00, 1, 1);
        check("unf_clr_vs_event", underflow, 1);
        step(0, 0, 8'h00, 0, 1);
        check("unf_clr_final", underflow, 0);

        // Randomized traffic in phases that push toward full, empty and balanced.
        for (int i = 0; i < 4000; i++) begin
            int wp;
            int rp;
            case ((i / 500) % 4)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 50; rp = 50; end
                2:       begin wp = 20; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            if (i == 2000) do_reset();
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 99) < wp,
                 W'($urandom),
                 $urandom_range(0, 99) < rp,
                 $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
